// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the two-requester shared-register arbiter:
// FSM state codes and a small helper that maps a requester index to its ownership state.
package shared_reg_arbiter_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    function automatic logic [1:0] own_state(input logic idx);
        return idx ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Request/grant/data bundle between the two requesters and the shared-register arbiter.
// master = requester side, slave = arbiter side.
interface shared_reg_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] d0;
    logic             req1;
    logic [WIDTH-1:0] d1;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic             ld;
    logic [WIDTH-1:0] q;

    modport master (
        output req0, d0, req1, d1,
        input  gnt0, gnt1, sel, ld, q
    );

    modport slave (
        input  req0, d0, req1, d1,
        output gnt0, gnt1, sel, ld, q
    );
endinterface

// File: rtl/shared_reg_arbiter_shared_reg.sv
// WIDTH-bit storage register fed by a 2:1 mux; ld=0 recirculates the current contents.
// Asynchronous active-low clear.
module shared_reg #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    input  logic             ld,
    input  logic             c,
    input  logic             re_,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d_mux;
    logic [WIDTH-1:0] d_next;

    assign d_mux  = sel ? d1 : d0;
    assign d_next = ld ? d_mux : q;

    always_ff @(posedge c or negedge re_) begin
        if (!re_) begin
            q <= '0;
        end else begin
            q <= d_next;
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one of two requesters ownership of a shared WIDTH-bit register,
// with a bounded hold time while the other requester is waiting.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                 c,
    input  logic                 re_,
    shared_reg_arbiter_if.slave  bus
);

    localparam int             CW        = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] hold_cnt;
    logic          last;
    logic          ld;
    logic          other_waiting;
    logic          gnt0_r;
    logic          gnt1_r;
    logic          sel_r;

    always_comb begin
        state_nxt     = IDLE;
        ld            = 1'b0;
        other_waiting = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_nxt = own_state(~last);
                end else if (bus.req0) begin
                    state_nxt = OWN0;
                end else if (bus.req1) begin
                    state_nxt = OWN1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OWN0: begin
                ld            = bus.req0;
                other_waiting = bus.req1;
                if (!bus.req0) begin
                    state_nxt = bus.req1 ? OWN1 : IDLE;
                end else if (bus.req1 && hold_cnt == HOLD_LAST) begin
                    state_nxt = OWN1;
                end else begin
                    state_nxt = OWN0;
                end
            end
            OWN1: begin
                ld            = bus.req1;
                other_waiting = bus.req0;
                if (!bus.req1) begin
                    state_nxt = bus.req0 ? OWN0 : IDLE;
                end else if (bus.req0 && hold_cnt == HOLD_LAST) begin
                    state_nxt = OWN0;
                end else begin
                    state_nxt = OWN1;
                end
            end
            // The unused code 2'd3 falls back to IDLE.
            default: state_nxt = IDLE;
        endcase
    end

    // Grants and select are flopped from the next state so they switch together with it.
    always_ff @(posedge c or negedge re_) begin
        if (!re_) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= 1'b1;
            gnt0_r   <= 1'b0;
            gnt1_r   <= 1'b0;
            sel_r    <= 1'b0;
        end else begin
            state  <= state_nxt;
            gnt0_r <= (state_nxt == OWN0);
            gnt1_r <= (state_nxt == OWN1);
            sel_r  <= (state_nxt == OWN1);
            if (state_nxt != state) begin
                hold_cnt <= '0;
            end else if (other_waiting && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (state_nxt == OWN0 && state != OWN0) begin
                last <= 1'b0;
            end else if (state_nxt == OWN1 && state != OWN1) begin
                last <= 1'b1;
            end
        end
    end

    assign bus.gnt0 = gnt0_r;
    assign bus.gnt1 = gnt1_r;
    assign bus.sel  = sel_r;
    assign bus.ld   = ld;

    shared_reg #(
        .WIDTH (WIDTH)
    ) u_shared_reg (
        .d0  (bus.d0),
        .d1  (bus.d1),
        .sel (sel_r),
        .ld  (ld),
        .c   (c),
        .re_ (re_),
        .q   (bus.q)
    );

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (WIDTH=4, MAX_HOLD=4) with hand-computed expectations.
module tb_shared_reg_arbiter;

    logic c;
    logic re_;
    int   pass_cnt;
    int   total_cnt;

    shared_reg_arbiter_if #(.WIDTH(4)) bus ();

    shared_reg_arbiter #(
        .WIDTH    (4),
        .MAX_HOLD (4)
    ) dut (
        .c   (c),
        .re_ (re_),
        .bus (bus.slave)
    );

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        re_       = 1'b0;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.d0    = 4'h0;
        bus.d1    = 4'h0;

        // Reset state
        tick();
        check("rst_gnt0", bus.gnt0, 0);
        check("rst_gnt1", bus.gnt1, 0);
        check("rst_sel",  bus.sel,  0);
        check("rst_q",    bus.q,    0);
        check("rst_ld",   bus.ld,   0);
        re_ = 1'b1;
        tick();
        check("idle_gnt1", bus.gnt1, 0);

        // Single requester 1
        bus.req1 = 1'b1;
        bus.d1   = 4'h5;
        tick();
        check("single_gnt1_c1", bus.gnt1, 1);
        check("single_sel_c1",  bus.sel,  1);
        check("single_q_c1",    bus.q,    0);
        check("single_ld_c1",   bus.ld,   1);
        tick();
        check("single_q_c2", bus.q, 4'h5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("single_gnt1_hold", bus.gnt1, 1);
            check("single_gnt0_hold", bus.gnt0, 0);
        end

        // Idle hold with q=9
        bus.d1 = 4'h9;
        tick();
        check("idle_q_load9", bus.q, 4'h9);
        bus.req1 = 1'b0;
        #1;
        check("idle_ld_release", bus.ld, 0);
        tick();
        check("idle_gnt1_drop", bus.gnt1, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_q_hold", bus.q, 4'h9);
            check("idle_ld", bus.ld, 0);
        end
        check("idle_gnt0", bus.gnt0, 0);
        check("idle_gnt1", bus.gnt1, 0);

        // Make requester 0 the last owner, then tie
        bus.req0 = 1'b1;
        bus.d0   = 4'h6;
        tick();
        check("own0_gnt0", bus.gnt0, 1);
        bus.req0 = 1'b0;
        tick();
        check("own0_release", bus.gnt0, 0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.d0   = 4'h6;
        bus.d1   = 4'h7;
        tick();
        check("tie_gnt1_wins", bus.gnt1, 1);
        check("tie_gnt0_low",  bus.gnt0, 0);

        // Fairness: 4 cycles each, starting with owner 1
        for (int k = 0; k < 12; k++) begin
            logic exp_own;
            logic prev_own;
            exp_own  = (((k / 4) % 2) == 0);
            prev_own = ((((k - 1) / 4) % 2) == 0);
            check("fair_gnt1", bus.gnt1, exp_own);
            check("fair_gnt0", bus.gnt0, !exp_own);
            check("fair_sel",  bus.sel,  exp_own);
            check("fair_not_both", bus.gnt0 & bus.gnt1, 0);
            if (k > 0) check("fair_q", bus.q, prev_own ? 4'h7 : 4'h6);
            tick();
        end
        check("fair_gnt0_k12", bus.gnt0, 1);

        // Handover: owner 0 releases while requester 1 waits
        bus.req0 = 1'b0;
        bus.d1   = 4'h3;
        #1;
        check("ho_ld_release", bus.ld, 0);
        tick();
        check("ho_gnt1", bus.gnt1, 1);
        check("ho_sel",  bus.sel,  1);
        check("ho_gnt0", bus.gnt0, 0);
        check("ho_no_old_load", bus.q, 4'h7);
        tick();
        check("ho_q3", bus.q, 4'h3);

        // Asynchronous reset mid-ownership
        bus.d1 = 4'hA;
        tick();
        check("rst_mid_qA", bus.q, 4'hA);
        check("rst_mid_gnt1_pre", bus.gnt1, 1);
        bus.req0 = 1'b1;
        re_      = 1'b0;
        #2;
        check("rst_mid_q",    bus.q,    0);
        check("rst_mid_gnt1", bus.gnt1, 0);
        check("rst_mid_sel",  bus.sel,  0);
        check("rst_mid_gnt0", bus.gnt0, 0);
        #2;
        re_ = 1'b1;
        tick();
        check("rst_tie_gnt0", bus.gnt0, 1);
        check("rst_tie_gnt1", bus.gnt1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
